muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit.
- Sits beside the ALU in the execute path:
  - Consumes the two register-file read operands.
  - Returns a 32-bit result plus a write strobe and destination index that drive the register-file write port (data, enable, address).
- Stalls the core through a busy flag while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the step counter width is $clog2(XLEN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value
- op_b  input  XLEN  rs2 value
- rd_in  input  5  destination register index
- busy  output  1  operation in flight; core stalls
- done  output  1  one-cycle result-valid pulse; drives register-file write enable
- rd_out  output  5  destination index latched at accept
- result  output  XLEN  result; held until the next accept

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. Reset forces state=IDLE, busy=0, done=0, result=0, rd_out=0, and clears all internal registers.
- States: IDLE, CALC, FIX, DONE.
  - busy=1 in CALC, FIX and DONE.
  - done=1 only in DONE.
- Accept:
  - In IDLE with start=1, latch funct3, rd_in and operand magnitudes plus sign flags.
  - Signed flags: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM. MUL's low word is sign-agnostic, so it runs unsigned.
- Normal path:
  - IDLE -> CALC: 32 cycles, step counter counts 0..31.
  - CALC -> FIX: one cycle; two's-complement negation of the result if needed.
  - FIX -> DONE: one cycle.
  - DONE -> IDLE.
  - done is high in the 34th cycle after the accepting edge.
- Multiply: unsigned shift-add of magnitudes into a 64-bit accumulator. Negate the 64-bit product in FIX if sign_a XOR sign_b. MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient is negated if signs differ.
  - Remainder takes the dividend's sign.
- Special cases (no CALC/FIX): IDLE -> DONE directly, done high the cycle after accept.
  - Divisor zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- start while busy=1, including in the DONE cycle: ignored. No queueing.
- Inputs are sampled only at accept; later operand changes have no effect.
- Reset asserted mid-operation: immediate abort, no done pulse.
- result and rd_out change only on the DONE transition; they are stable at all other times.

Optional Feature:
- MULDIV_FAST_MUL_EN
- Defined: all four multiply ops complete in a single cycle.
  - IDLE -> DONE using a combinational 33x33 signed product of sign-extended operands.
  - done is high the cycle after accept.
  - Divide is unchanged.
- Undefined: multiplies use the iterative 34-cycle path. No multiplier inferred.

Decomposition:
- Package muldiv_pkg holds:
  - XLEN constant.
  - Enum muldiv_op_e for the funct3 encodings.
  - Enum muldiv_state_e {IDLE, CALC, FIX, DONE}.
  - Constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- No sub-module required. The shared shift/add-subtract datapath stays in one module.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done at cycle 34, result=0xFFFFFFEB, rd_out=rd_in=5; busy=1 cycles 1..34.
- MULH a=0x80000000, b=0x80000000 -> result=0x40000000; MULHU same operands -> 0x40000000; MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIV/REM a=0x12345678, b=0 -> 0xFFFFFFFF / 0x12345678; DIV a=0x80000000, b=-1 -> 0x80000000 with done one cycle after accept; REM same operands -> 0.
- start pulsed at cycles 10 and 34 of a running op -> both ignored, exactly one done. Back-to-back start immediately after done -> accepted.
- rst_n low at cycle 15 of a DIV -> busy=0, done=0, result=0 asynchronously. A new DIVU 9/3 after release -> 3.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  // Value of the step counter in the final CALC cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  // rs1 is treated as signed; MUL's low word is sign-agnostic so it runs unsigned
  function automatic logic a_is_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic b_is_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiply: 32-step unsigned shift-add on magnitudes, sign fixed up afterwards.
// Divide:   32-step restoring division on magnitudes, signs fixed up afterwards.
// Divide-by-zero and signed overflow complete the cycle after accept.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish the cycle after accept
// using a combinational 33x33 signed product; divide is unaffected.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  muldiv_state_e state, state_nx;

  muldiv_op_e      op_in, op_q;
  logic [4:0]      rd_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] opnd_q;          // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0] hi_q, lo_q;      // product hi/lo, or remainder/quotient
  logic [CNT_W-1:0] cnt_q;

  logic            accept;
  logic            is_mul_in;
  logic            sa_in, sb_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div0_in, ovf_in, special_in;
  logic [XLEN-1:0] special_res;
  logic            fast_take;
  logic [XLEN-1:0] fast_res;
  logic            short_in;
  logic [XLEN-1:0] short_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] mul_prod, mul_fixed;
  logic [XLEN-1:0]   quot_fixed, rem_fixed;
  logic [XLEN-1:0]   fix_res;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Operand decode and sign/magnitude split at accept time
  assign op_in     = muldiv_op_e'(funct3);
  assign accept    = (state == IDLE) && start;
  assign is_mul_in = ~funct3[2];
  assign sa_in     = a_is_signed(op_in) & op_a[XLEN-1];
  assign sb_in     = b_is_signed(op_in) & op_b[XLEN-1];
  assign mag_a     = sa_in ? -op_a : op_a;
  assign mag_b     = sb_in ? -op_b : op_b;

  // Division corner cases resolved without iterating
  assign div0_in     = funct3[2] && (op_b == '0);
  assign ovf_in      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (op_a == INT_MIN) && (op_b == '1);
  assign special_in  = div0_in | ovf_in;
  assign special_res = div0_in ? (funct3[1] ? op_a : DIV0_QUOT)
                               : (funct3[1] ? '0   : INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_prod;

  assign fast_a    = $signed({a_is_signed(op_in) & op_a[XLEN-1], op_a});
  assign fast_b    = $signed({b_is_signed(op_in) & op_b[XLEN-1], op_b});
  assign fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
  assign fast_take = is_mul_in;
  assign fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_take = 1'b0;
  assign fast_res  = '0;
`endif

  assign short_in  = special_in | fast_take;
  assign short_res = special_in ? special_res : fast_res;

  // One shift-add or one restoring-subtract step of the shared datapath
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the true difference is below opnd_q, so 32 bits suffice
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
  end

  // Sign fix-up and result selection evaluated during FIX
  always_comb begin
    mul_prod   = {hi_q, lo_q};
    mul_fixed  = (sa_q ^ sb_q) ? -mul_prod : mul_prod;
    quot_fixed = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem_fixed  = sa_q ? -hi_q : hi_q;
    fix_res    = '0;
    unique case (op_q)
      OP_MUL:                        fix_res = mul_fixed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = mul_fixed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quot_fixed;
      OP_REM, OP_REMU:               fix_res = rem_fixed;
      default:                       fix_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = short_in ? DONE : CALC;
      CALC:    if (cnt_q == CNT_LAST) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result/rd_out update on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      rd_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            rd_q  <= rd_in;
            sa_q  <= sa_in;
            sb_q  <= sb_in;
            cnt_q <= '0;
            hi_q  <= '0;
            if (is_mul_in) begin
              opnd_q <= mag_a;
              lo_q   <= mag_b;
            end else begin
              opnd_q <= mag_b;
              lo_q   <= mag_a;
            end
            if (short_in) begin
              result <= short_res;
              rd_out <= rd_in;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!op_q[2]) begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end else if (div_ge) begin
            hi_q <= div_diff;
            lo_q <= {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_q <= div_shift[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b0};
          end
        end
        FIX: begin
          result <= fix_res;
          rd_out <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .rd_out (rd_out),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, wait (bounded) for done.
  // lat is the cycle index after the accepting edge in which done was seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo, output logic busy_all);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    rd_in  = 5'($urandom);
    lat = 1;
    busy_all = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_all = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) busy_all = 1'b0;
    res = result;
    rdo = rd_out;
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  task automatic op(input string tag, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] rd,
                    input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] res;
    logic [4:0] rdo;
    logic ball;
    run_op(f, a, b, rd, lat, res, rdo, ball);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rd_out"}, {27'b0, rdo}, {27'b0, rd});
  endtask

  initial begin
    int lat;
    int ndone;
    int done_cyc;
    logic seen_done;
    logic [31:0] res;
    logic [4:0] rdo;
    logic ball;

    rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'b0, busy},   32'd0);
    check("rst_done",   {31'b0, done},   32'd0);
    check("rst_result", result,          32'd0);
    check("rst_rd_out", {27'b0, rd_out}, 32'd0);
    rst_n = 1'b1;

    // MUL 7 * -3, busy throughout cycles 1..34
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, res, rdo, ball);
    check("mul_result",  res, 32'hFFFF_FFEB);
    check("mul_latency", 32'(lat), 32'(MUL_LAT));
    check("mul_rd_out",  {27'b0, rdo}, 32'd5);
    check("mul_busy",    {31'b0, ball}, 32'd1);
    check("mul_idle_after", {31'b0, busy}, 32'd0);

    op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, MUL_LAT);
    op("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, MUL_LAT);
    op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, MUL_LAT);

    op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, DIV_LAT);
    op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, DIV_LAT);
    op("divu", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14, DIV_LAT);
    op("remu", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, DIV_LAT);

    op("div0",  3'b100, 32'h1234_5678, 32'd0, 5'd9,  32'hFFFF_FFFF, 1);
    op("rem0",  3'b110, 32'h1234_5678, 32'd0, 5'd10, 32'h1234_5678, 1);
    op("divu0", 3'b101, 32'h0000_0042, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    op("divov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
    op("remov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);

    // DIVU 1000/10 with start re-pulsed at cycles 10 and 34 (the DONE cycle)
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd10; rd_in = 5'd14; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'b100; op_a = 32'd7; op_b = 32'd7; rd_in = 5'd20;
    ndone = 0;
    done_cyc = 0;
    for (int c = 1; c <= 45; c++) begin
      if (done === 1'b1) begin
        ndone++;
        done_cyc = c;
      end
      start = (c == 10 || c == 34) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_done_cycle", 32'(done_cyc), 32'd34);
    check("ignore_result", result, 32'd100);
    check("ignore_rd_out", {27'b0, rd_out}, 32'd14);
    check("ignore_idle", {31'b0, busy}, 32'd0);

    // Back-to-back: second op starts in the first IDLE cycle after done
    op("b2b_first",  3'b111, 32'd17, 32'd5, 5'd15, 32'd2, DIV_LAT);
    op("b2b_second", 3'b101, 32'd17, 32'd5, 5'd16, 32'd3, DIV_LAT);

    // Reset asserted at cycle 15 of a DIV
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'b0, busy},   32'd0);
    check("async_rst_done",   {31'b0, done},   32'd0);
    check("async_rst_result", result,          32'd0);
    check("async_rst_rd_out", {27'b0, rd_out}, 32'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", {31'b0, seen_done}, 32'd0);

    op("post_rst_divu", 3'b101, 32'd9, 32'd3, 5'd18, 32'd3, DIV_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
